// File: rtl/drive_z_corr_scheduler_pkg.sv
// Shared types and default widths for the drive-circuit Z-correction scheduler.
package drive_ctrl_pkg;

  localparam int NUM_QUBIT_PER_BANK        = 16;
  localparam int QUBIT_ADDR_WIDTH_PER_BANK = 4;
  localparam int DUR_WIDTH                 = 8;
  localparam int FIFO_DEPTH                = 4;
  localparam int FIFO_AW                   = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CORR    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_FIN     = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0] qubit;
    logic [DUR_WIDTH-1:0]                 duration;
  } z_corr_req_t;

  // A zero-length window is served as a single cycle.
  function automatic logic [DUR_WIDTH-1:0] eff_duration(input logic [DUR_WIDTH-1:0] dur);
    return (dur == '0) ? DUR_WIDTH'(1) : dur;
  endfunction

endpackage

// File: rtl/drive_z_corr_scheduler_if.sv
// Request/status bundle between the instruction table and the Z-correction scheduler.
interface drive_z_corr_scheduler_if;
  import drive_ctrl_pkg::*;

  logic                                 req_valid;
  logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0] req_qubit;
  logic [DUR_WIDTH-1:0]                 req_duration;
  logic                                 req_ready;
  logic                                 abort;
  logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0] qubit_sel;
  logic                                 local_is_read_env_fin;
  logic                                 glb_is_read_env_fin;
  logic                                 busy;
  logic [NUM_QUBIT_PER_BANK-1:0]        pending;
  logic                                 dup_err;

  modport master (
    output req_valid, req_qubit, req_duration, abort,
    input  req_ready, qubit_sel, local_is_read_env_fin, glb_is_read_env_fin,
           busy, pending, dup_err
  );

  modport slave (
    input  req_valid, req_qubit, req_duration, abort,
    output req_ready, qubit_sel, local_is_read_env_fin, glb_is_read_env_fin,
           busy, pending, dup_err
  );

endinterface

// File: rtl/drive_z_corr_scheduler_fifo.sv
// Request queue: pointers carry one extra wrap bit so full and empty are distinguishable.
module z_corr_req_fifo
  import drive_ctrl_pkg::*;
#(
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  z_corr_req_t push_data_i,
  input  logic        pop_i,
  output z_corr_req_t pop_data_o,
  input  logic        flush_i,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  z_corr_req_t mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        do_push;
  logic        do_pop;

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/drive_z_corr_scheduler.sv
// Per-bank Z-correction sequencer: queues one request per qubit and opens one
// correction window at a time, pulsing glb_is_read_env_fin when the queue drains.
module drive_z_corr_scheduler
  import drive_ctrl_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  drive_z_corr_scheduler_if.slave bus
);

  sched_state_e                         state_q, state_d;
  logic [DUR_WIDTH-1:0]                 cnt_q, cnt_d;
  logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0] qubit_sel_q, qubit_sel_d;
  logic [NUM_QUBIT_PER_BANK-1:0]        pending_q, pending_d;
  logic                                 dup_err_q, dup_err_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_AW:0] fifo_count;
  z_corr_req_t      push_entry, head;
  logic             req_take, req_is_dup, load_next;

  // A request reaching a non-full queue is either queued or flagged as a duplicate.
  assign req_take   = bus.req_valid && !fifo_full;
  assign req_is_dup = req_take && pending_q[bus.req_qubit];
  assign fifo_push  = req_take && !pending_q[bus.req_qubit] && !bus.abort;
  assign push_entry = '{qubit: bus.req_qubit, duration: bus.req_duration};

  z_corr_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .pop_data_o  (head),
    .flush_i     (bus.abort),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    qubit_sel_d = qubit_sel_q;
    pending_d   = pending_q;
    fifo_pop    = 1'b0;
    load_next   = 1'b0;
    dup_err_d   = req_is_dup && !bus.abort;

    unique case (state_q)
      ST_IDLE:    load_next = !fifo_empty;
      ST_LOAD:    state_d = ST_CORR;
      ST_CORR: begin
        cnt_d = cnt_q - DUR_WIDTH'(1);
        if (cnt_q == DUR_WIDTH'(1)) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        pending_d[qubit_sel_q] = 1'b0;
        if (!fifo_empty) load_next = 1'b1;
        else             state_d   = ST_FIN;
      end
      ST_FIN:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (load_next) begin
      fifo_pop    = 1'b1;
      qubit_sel_d = head.qubit;
      cnt_d       = eff_duration(head.duration);
      state_d     = ST_LOAD;
    end

    if (fifo_push) pending_d[bus.req_qubit] = 1'b1;

    // Abort drops everything in flight but leaves qubit_sel at its last value.
    if (bus.abort) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      pending_d   = '0;
      fifo_pop    = 1'b0;
      qubit_sel_d = qubit_sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      qubit_sel_q <= '0;
      pending_q   <= '0;
      dup_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      qubit_sel_q <= qubit_sel_d;
      pending_q   <= pending_d;
      dup_err_q   <= dup_err_d;
    end
  end

  assign bus.req_ready             = !fifo_full;
  assign bus.qubit_sel             = qubit_sel_q;
  assign bus.local_is_read_env_fin = (state_q == ST_CORR);
  assign bus.glb_is_read_env_fin   = (state_q == ST_FIN);
  assign bus.busy                  = (state_q != ST_IDLE) || (fifo_count != '0);
  assign bus.pending               = pending_q;
  assign bus.dup_err               = dup_err_q;

endmodule

// File: tb/tb_drive_z_corr_scheduler.sv
// Scoreboard bench for drive_z_corr_scheduler: a timeline model predicts every
// correction window, glb pulse and dup_err pulse by the edge on which it appears.
module tb_drive_z_corr_scheduler;
  import drive_ctrl_pkg::*;

  typedef struct { int qubit; int len; } ent_t;
  typedef struct { int qubit; int start; int len; } win_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  drive_z_corr_scheduler_if bus ();
  drive_z_corr_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Reference model: queue contents, pending set, and the edge numbers at which
  // the current service window starts and its RELEASE cycle ends.
  ent_t       mq[$];
  logic [15:0] m_pend;
  bit         m_cur, m_acc, m_full;
  int         m_cur_q, m_sel, m_start, m_len, m_rel, m_free;
  win_t       exp_win[$];
  int         exp_glb[$];
  int         exp_dup[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic report_event(input string name, input string what, input int at);
    checks++;
    errors++;
    $display("FAIL %s: %s event, expected at edge %0d, now edge %0d", name, what, at, edge_n);
  endtask

  function automatic bit model_busy(input int t);
    return m_cur || (mq.size() > 0) || (t + 1 < m_free);
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_win.delete();
    exp_glb.delete();
    exp_dup.delete();
    m_pend = '0;
    m_cur  = 1'b0;
    m_acc  = 1'b0;
    m_full = 1'b0;
    m_sel  = 0;
    m_free = 0;
  endtask

  // Predicts the effect of the inputs sampled at edge t.
  task automatic model_step(input int t, input bit v, input int q, input int d, input bit a);
    bit   ready, dup, push, do_pop;
    ent_t e;
    win_t w;
    ready  = mq.size() < FIFO_DEPTH;
    dup    = v && ready && m_pend[q];
    push   = v && ready && !m_pend[q];
    m_acc  = 1'b0;
    m_full = !ready;
    if (a) begin
      if (m_cur && t <= m_start) begin
        void'(exp_win.pop_back());
      end else if (m_cur && t < m_start + m_len) begin
        w = exp_win.pop_back();
        w.len = t - m_start;
        exp_win.push_back(w);
      end
      mq.delete();
      m_pend = '0;
      m_cur  = 1'b0;
      m_free = t + 1;
      return;
    end
    if (dup) exp_dup.push_back(t);
    do_pop = 1'b0;
    if (m_cur && t == m_rel) begin
      m_pend[m_cur_q] = 1'b0;
      m_cur = 1'b0;
      if (mq.size() > 0) do_pop = 1'b1;
      else begin
        exp_glb.push_back(t);
        m_free = t + 2;
      end
    end else if (!m_cur && t >= m_free && mq.size() > 0) begin
      do_pop = 1'b1;
    end
    if (do_pop) begin
      e = mq.pop_front();
      m_cur   = 1'b1;
      m_cur_q = e.qubit;
      m_sel   = e.qubit;
      m_start = t + 1;
      m_len   = e.len;
      m_rel   = t + 2 + e.len;
      exp_win.push_back('{e.qubit, t + 1, e.len});
    end
    if (push) begin
      e.qubit = q;
      e.len   = (d == 0) ? 1 : d;
      mq.push_back(e);
      m_pend[q] = 1'b1;
      m_acc = 1'b1;
    end
  endtask

  task automatic cycle(input bit v, input int q, input int d, input bit a);
    @(negedge clk);
    bus.req_valid    = v;
    bus.req_qubit    = QUBIT_ADDR_WIDTH_PER_BANK'(q);
    bus.req_duration = DUR_WIDTH'(d);
    bus.abort        = a;
    model_step(edge_n + 1, v, q, d, a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0);
  endtask

  // Holds the request while the queue is full, up to a cycle budget.
  task automatic send(input int q, input int d);
    int n;
    n = 0;
    do begin
      cycle(1'b1, q, d, 1'b0);
      n++;
    end while (m_full && n < 200);
    if (m_full) report_event("send_holdoff", "never accepted", edge_n);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_busy"},      32'(bus.busy), 32'd0);
    check({tag, "_pending"},   32'(bus.pending), 32'd0);
    check({tag, "_qubit_sel"}, 32'(bus.qubit_sel), 32'd0);
    check({tag, "_local"},     32'(bus.local_is_read_env_fin), 32'd0);
    check({tag, "_glb"},       32'(bus.glb_is_read_env_fin), 32'd0);
    check({tag, "_dup_err"},   32'(bus.dup_err), 32'd0);
  endtask

  task automatic run_random(input int n);
    bit v, a, hold;
    int rq, rd;
    hold = 1'b0;
    rq = 0;
    rd = 0;
    for (int i = 0; i < n; i++) begin
      if (!hold) begin
        v  = ($urandom_range(0, 99) < 45);
        rq = $urandom_range(0, 15);
        rd = $urandom_range(0, 9);
      end else begin
        v = 1'b1;
      end
      a = ($urandom_range(0, 99) == 0);
      cycle(v, rq, rd, a);
      hold = v && m_full && !a;
    end
  endtask

  // Monitor: per-cycle status against the model, events against the scoreboard.
  initial begin : monitor
    bit   prev_local;
    int   w_start, w_q, exp_e;
    win_t w;
    prev_local = 1'b0;
    w_start = 0;
    w_q = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        prev_local = 1'b0;
      end else begin
        check("req_ready", 32'(bus.req_ready), 32'(mq.size() < FIFO_DEPTH));
        check("pending",   32'(bus.pending), 32'(m_pend));
        check("busy",      32'(bus.busy), 32'(model_busy(edge_n)));
        check("qubit_sel", 32'(bus.qubit_sel), 32'(m_sel));

        if (bus.local_is_read_env_fin && !prev_local) begin
          w_start = edge_n;
          w_q = int'(bus.qubit_sel);
        end
        if (!bus.local_is_read_env_fin && prev_local) begin
          if (exp_win.size() == 0) report_event("window", "unexpected", edge_n);
          else begin
            w = exp_win.pop_front();
            check("win_qubit", 32'(w_q), 32'(w.qubit));
            check("win_start", 32'(w_start), 32'(w.start));
            check("win_len",   32'(edge_n - w_start), 32'(w.len));
          end
        end else if (!bus.local_is_read_env_fin && exp_win.size() > 0 && exp_win[0].start < edge_n) begin
          report_event("window", "missing", exp_win[0].start);
          void'(exp_win.pop_front());
        end
        prev_local = bus.local_is_read_env_fin;

        while (exp_glb.size() > 0 && exp_glb[0] < edge_n) begin
          report_event("glb", "missing", exp_glb[0]);
          void'(exp_glb.pop_front());
        end
        if (bus.glb_is_read_env_fin) begin
          if (exp_glb.size() == 0) report_event("glb", "unexpected", edge_n);
          else begin
            exp_e = exp_glb.pop_front();
            check("glb_edge", 32'(edge_n), 32'(exp_e));
          end
        end

        while (exp_dup.size() > 0 && exp_dup[0] < edge_n) begin
          report_event("dup_err", "missing", exp_dup[0]);
          void'(exp_dup.pop_front());
        end
        if (bus.dup_err) begin
          if (exp_dup.size() == 0) report_event("dup_err", "unexpected", edge_n);
          else begin
            exp_e = exp_dup.pop_front();
            check("dup_edge", 32'(edge_n), 32'(exp_e));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    bus.req_valid    = 1'b0;
    bus.req_qubit    = '0;
    bus.req_duration = '0;
    bus.abort        = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst = 1'b1;

    // Single request into an empty queue.
    send(5, 3);
    idle(12);

    // Back-to-back service with a zero-length window last.
    send(2, 2);
    send(9, 4);
    send(12, 0);
    idle(25);

    // Fill the queue while qubit 0 is in its window; the fifth request waits.
    send(0, 8);
    idle(2);
    for (int q = 1; q <= 4; q++) send(q, 2);
    send(5, 1);
    idle(40);

    // Duplicate while queued, then duplicate while in RELEASE.
    send(7, 5);
    send(7, 2);
    idle(15);
    send(7, 1);
    idle(3);
    send(7, 1);
    idle(10);

    // Abort mid-window with two queued entries and a colliding request.
    send(3, 10);
    send(4, 2);
    send(6, 2);
    idle(2);
    cycle(1'b1, 4, 3, 1'b1);
    idle(8);

    // Asynchronous reset mid-window, then normal service resumes.
    send(10, 6);
    idle(3);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(11, 2);
    idle(10);

    run_random(1500);
    idle(120);

    check("left_windows", 32'(exp_win.size()), 32'd0);
    check("left_glb",     32'(exp_glb.size()), 32'd0);
    check("left_dup",     32'(exp_dup.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
